// File: rtl/xcom_cmd_arbiter_if.sv
// Command-port bundle for xcom_cmd_arbiter.
// Carries the PS and tProc enqueue ports, the flush pulse, the TX core command
// handshake, the done pulse and the status flags.
// slave  : the arbiter side (consumes requests, drives the TX command).
// master : the surrounding logic (drives requests, observes the TX command).
// XCOM_ARB_STATS_EN adds the stat_* counters to the bundle.
interface xcom_cmd_arbiter_if;
  logic        flush_i;
  logic        ps_req_i;
  logic [4:0]  ps_op_i;
  logic [31:0] ps_dt1_i;
  logic [31:0] ps_dt2_i;
  logic        ps_rdy_o;
  logic        qp_req_i;
  logic [4:0]  qp_op_i;
  logic [31:0] qp_dt1_i;
  logic [31:0] qp_dt2_i;
  logic        qp_rdy_o;
  logic        cmd_vld_o;
  logic        cmd_rdy_i;
  logic [4:0]  cmd_op_o;
  logic [31:0] cmd_dt1_o;
  logic [31:0] cmd_dt2_o;
  logic        cmd_src_o;
  logic        tx_done_i;
  logic        busy_o;
  logic        tmo_err_o;
  logic        ovf_err_o;
`ifdef XCOM_ARB_STATS_EN
  logic [15:0] stat_ps_o;
  logic [15:0] stat_qp_o;
  logic [7:0]  stat_tmo_o;
`endif

  modport slave (
`ifdef XCOM_ARB_STATS_EN
    output stat_ps_o, stat_qp_o, stat_tmo_o,
`endif
    input  flush_i,
    input  ps_req_i, ps_op_i, ps_dt1_i, ps_dt2_i,
    output ps_rdy_o,
    input  qp_req_i, qp_op_i, qp_dt1_i, qp_dt2_i,
    output qp_rdy_o,
    output cmd_vld_o, cmd_op_o, cmd_dt1_o, cmd_dt2_o, cmd_src_o,
    input  cmd_rdy_i,
    input  tx_done_i,
    output busy_o, tmo_err_o, ovf_err_o
  );

  modport master (
`ifdef XCOM_ARB_STATS_EN
    input  stat_ps_o, stat_qp_o, stat_tmo_o,
`endif
    output flush_i,
    output ps_req_i, ps_op_i, ps_dt1_i, ps_dt2_i,
    input  ps_rdy_o,
    output qp_req_i, qp_op_i, qp_dt1_i, qp_dt2_i,
    input  qp_rdy_o,
    input  cmd_vld_o, cmd_op_o, cmd_dt1_o, cmd_dt2_o, cmd_src_o,
    output cmd_rdy_i,
    output tx_done_i,
    input  busy_o, tmo_err_o, ovf_err_o
  );
endinterface

// File: rtl/xcom_cmd_arbiter.sv
// xcom_cmd_arbiter: shares the XCOM TX command port between the PS register
// path (source 0) and the tProcessor qp path (source 1).
// Each source owns a 2**FIFO_AW deep command FIFO. An IDLE/ISSUE/WAIT machine
// pops one command, presents it to the TX core until cmd_rdy_i, then waits for
// tx_done_i or TMO_CYC cycles before choosing again.
// Ports:
//   c_clk, c_rst : command clock, synchronous active-high reset
//   bus (slave)  : flush_i, ps_*/qp_* enqueue ports with rdy_o = !full,
//                  cmd_* TX handshake, tx_done_i, busy_o, tmo_err_o, ovf_err_o
// Parameters: FIFO_AW (log2 FIFO depth), PRIO (0 round-robin, 1 tProc first),
//             TMO_CYC (WAIT timeout in cycles).
// Optional: define XCOM_ARB_STATS_EN for saturating grant/timeout counters
//           stat_ps_o, stat_qp_o, stat_tmo_o.
module xcom_cmd_arbiter #(
  parameter int unsigned FIFO_AW = 2,
  parameter int unsigned PRIO    = 0,
  parameter int unsigned TMO_CYC = 4096
) (
  input logic               c_clk,
  input logic               c_rst,
  xcom_cmd_arbiter_if.slave bus
);

  localparam int unsigned   DEPTH    = 1 << FIFO_AW;
  localparam int unsigned   TW       = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] dt1;
    logic [31:0] dt2;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state, state_next;

  // Index 0 = PS, index 1 = tProc; matches the cmd_src_o encoding.
  logic             req      [2];
  cmd_t             req_cmd  [2];
  cmd_t             mem      [2][DEPTH];
  logic [FIFO_AW:0] wr_ptr   [2];
  logic [FIFO_AW:0] rd_ptr   [2];
  logic             empty    [2];
  logic             full     [2];
  logic             push     [2];
  logic             pop      [2];
  logic             ovf_evt  [2];

  logic          do_pop;
  logic          pop_src;
  logic          hs;
  logic          tmo_evt;
  logic          rr_ptr;
  logic [TW-1:0] timer;
  cmd_t          head;
  cmd_t          cmd_q;
  logic          src_q;
  logic          vld_q;
  logic          tmo_q;
  logic          ovf_q;

  always_comb begin
    req[0]     = bus.ps_req_i;
    req[1]     = bus.qp_req_i;
    req_cmd[0] = {bus.ps_op_i, bus.ps_dt1_i, bus.ps_dt2_i};
    req_cmd[1] = {bus.qp_op_i, bus.qp_dt1_i, bus.qp_dt2_i};
  end

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
      full[i]  = (wr_ptr[i][FIFO_AW] != rd_ptr[i][FIFO_AW]) &&
                 (wr_ptr[i][FIFO_AW-1:0] == rd_ptr[i][FIFO_AW-1:0]);
    end
  end

  always_comb begin
    state_next = state;
    do_pop     = 1'b0;
    pop_src    = 1'b0;
    hs         = 1'b0;
    tmo_evt    = 1'b0;
    case (state)
      IDLE: begin
        // A flush in IDLE wins over the pop so nothing stale is issued.
        if (!bus.flush_i && (!empty[0] || !empty[1])) begin
          do_pop = 1'b1;
          if (PRIO != 0)
            pop_src = !empty[1];
          else if (!empty[0] && !empty[1])
            pop_src = rr_ptr;
          else
            pop_src = !empty[1];
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.cmd_rdy_i) begin
          hs         = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (bus.tx_done_i) begin
          state_next = IDLE;
        end else if (timer == TMO_LAST) begin
          tmo_evt    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      pop[i]     = do_pop && (pop_src == 1'(i));
      push[i]    = req[i] && !bus.flush_i && (!full[i] || pop[i]);
      ovf_evt[i] = req[i] && !bus.flush_i && full[i] && !pop[i];
    end
  end

  assign head = mem[pop_src][rd_ptr[pop_src][FIFO_AW-1:0]];

  always_ff @(posedge c_clk) begin
    for (int unsigned i = 0; i < 2; i++) begin
      if (push[i])
        mem[i][wr_ptr[i][FIFO_AW-1:0]] <= req_cmd[i];
    end
  end

  always_ff @(posedge c_clk) begin
    if (c_rst) begin
      state  <= IDLE;
      rr_ptr <= 1'b0;
      timer  <= '0;
      cmd_q  <= '0;
      src_q  <= 1'b0;
      vld_q  <= 1'b0;
      tmo_q  <= 1'b0;
      ovf_q  <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      state <= state_next;

      if (do_pop) begin
        cmd_q  <= head;
        src_q  <= pop_src;
        vld_q  <= 1'b1;
        rr_ptr <= !pop_src;
      end

      if (hs) begin
        vld_q <= 1'b0;
        timer <= '0;
      end else if (state == WAIT) begin
        timer <= timer + 1'b1;
      end

      for (int unsigned i = 0; i < 2; i++) begin
        if (bus.flush_i) begin
          wr_ptr[i] <= '0;
          rd_ptr[i] <= '0;
        end else begin
          if (push[i])
            wr_ptr[i] <= wr_ptr[i] + 1'b1;
          if (pop[i])
            rd_ptr[i] <= rd_ptr[i] + 1'b1;
        end
      end

      if (bus.flush_i)
        tmo_q <= 1'b0;
      else if (tmo_evt)
        tmo_q <= 1'b1;

      if (bus.flush_i)
        ovf_q <= 1'b0;
      else if (ovf_evt[0] || ovf_evt[1])
        ovf_q <= 1'b1;
    end
  end

  assign bus.cmd_vld_o = vld_q;
  assign bus.cmd_op_o  = cmd_q.op;
  assign bus.cmd_dt1_o = cmd_q.dt1;
  assign bus.cmd_dt2_o = cmd_q.dt2;
  assign bus.cmd_src_o = src_q;
  assign bus.ps_rdy_o  = !full[0];
  assign bus.qp_rdy_o  = !full[1];
  assign bus.busy_o    = (state != IDLE) || !empty[0] || !empty[1];
  assign bus.tmo_err_o = tmo_q;
  assign bus.ovf_err_o = ovf_q;

`ifdef XCOM_ARB_STATS_EN
  logic [15:0] stat_ps;
  logic [15:0] stat_qp;
  logic [7:0]  stat_tmo;

  always_ff @(posedge c_clk) begin
    if (c_rst || bus.flush_i) begin
      stat_ps  <= '0;
      stat_qp  <= '0;
      stat_tmo <= '0;
    end else begin
      if (pop[0] && (stat_ps != '1))
        stat_ps <= stat_ps + 1'b1;
      if (pop[1] && (stat_qp != '1))
        stat_qp <= stat_qp + 1'b1;
      if (tmo_evt && (stat_tmo != '1))
        stat_tmo <= stat_tmo + 1'b1;
    end
  end

  assign bus.stat_ps_o  = stat_ps;
  assign bus.stat_qp_o  = stat_qp;
  assign bus.stat_tmo_o = stat_tmo;
`endif

endmodule

// File: tb/tb_xcom_cmd_arbiter.sv
// Bench for xcom_cmd_arbiter: a table of single-cycle vectors, directed
// sequences for ordering, FIFO-full, timeout and reset cases, then random
// traffic compared each cycle against a queue-based reference model of the
// PRIO=0 instance. A PRIO=1 instance runs in parallel for the ordering case.
module tb_xcom_cmd_arbiter;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned TMO   = 16;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
  } c_t;

  typedef struct {
    logic rst, flush, ps, qp;
    logic [4:0] pop, qop;
    logic rdy, done;
    logic vld;
    logic [4:0] op;
    logic src, busy, prdy, qrdy, tmo, ovf;
  } vec_t;

  logic        clk;
  logic        rst, flush, ps_req, qp_req, cmd_rdy, tx_done;
  logic [4:0]  ps_op, qp_op;
  logic [31:0] ps_dt1, ps_dt2, qp_dt1, qp_dt2;

  int passed = 0;
  int total  = 0;

  xcom_cmd_arbiter_if if0 ();
  xcom_cmd_arbiter_if if1 ();

  assign if0.flush_i = flush;   assign if1.flush_i = flush;
  assign if0.ps_req_i = ps_req; assign if1.ps_req_i = ps_req;
  assign if0.ps_op_i = ps_op;   assign if1.ps_op_i = ps_op;
  assign if0.ps_dt1_i = ps_dt1; assign if1.ps_dt1_i = ps_dt1;
  assign if0.ps_dt2_i = ps_dt2; assign if1.ps_dt2_i = ps_dt2;
  assign if0.qp_req_i = qp_req; assign if1.qp_req_i = qp_req;
  assign if0.qp_op_i = qp_op;   assign if1.qp_op_i = qp_op;
  assign if0.qp_dt1_i = qp_dt1; assign if1.qp_dt1_i = qp_dt1;
  assign if0.qp_dt2_i = qp_dt2; assign if1.qp_dt2_i = qp_dt2;
  assign if0.cmd_rdy_i = cmd_rdy; assign if1.cmd_rdy_i = cmd_rdy;
  assign if0.tx_done_i = tx_done; assign if1.tx_done_i = tx_done;

  xcom_cmd_arbiter #(.FIFO_AW(AW), .PRIO(0), .TMO_CYC(TMO)) dut0 (
    .c_clk(clk), .c_rst(rst), .bus(if0.slave));
  xcom_cmd_arbiter #(.FIFO_AW(AW), .PRIO(1), .TMO_CYC(TMO)) dut1 (
    .c_clk(clk), .c_rst(rst), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state (PRIO=0 instance)
  c_t   psq[$];
  c_t   qpq[$];
  int   m_phase;   // 0 idle, 1 offering a command, 2 awaiting done
  int   m_timer;
  bit   m_ptr;
  bit   m_vld, m_src, m_tmo, m_ovf;
  c_t   m_cmd;
  int   m_sps, m_sqp, m_stmo;

  logic [5:0] log0[$];
  logic [5:0] log1[$];
  bit   hs0;
  bit   auto_done;
  int   done_cnt;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_update();
    bit pick_v, pick, ps_full, qp_full;
    int p;
    if (rst) begin
      psq.delete(); qpq.delete();
      m_phase = 0; m_timer = 0; m_ptr = 0; m_vld = 0; m_src = 0;
      m_cmd = '0; m_tmo = 0; m_ovf = 0; m_sps = 0; m_sqp = 0; m_stmo = 0;
      return;
    end
    ps_full = (psq.size() == DEPTH);
    qp_full = (qpq.size() == DEPTH);
    p = m_phase;
    pick_v = 0;
    pick = 0;
    if (p == 0 && !flush && (psq.size() != 0 || qpq.size() != 0)) begin
      pick_v = 1;
      if (psq.size() != 0 && qpq.size() != 0) pick = m_ptr;
      else pick = (qpq.size() != 0);
      m_cmd = pick ? qpq.pop_front() : psq.pop_front();
      m_src = pick; m_vld = 1; m_ptr = !pick; m_phase = 1;
      if (pick) m_sqp = (m_sqp < 65535) ? m_sqp + 1 : m_sqp;
      else      m_sps = (m_sps < 65535) ? m_sps + 1 : m_sps;
    end else if (p == 1 && cmd_rdy) begin
      m_vld = 0; m_phase = 2; m_timer = 0;
    end else if (p == 2) begin
      if (tx_done) m_phase = 0;
      else if (m_timer == TMO - 1) begin
        m_tmo = 1; m_phase = 0;
        m_stmo = (m_stmo < 255) ? m_stmo + 1 : m_stmo;
      end else m_timer++;
    end
    if (!flush) begin
      if (ps_req) begin
        if (!ps_full || (pick_v && !pick)) psq.push_back({ps_op, ps_dt1, ps_dt2});
        else m_ovf = 1;
      end
      if (qp_req) begin
        if (!qp_full || (pick_v && pick)) qpq.push_back({qp_op, qp_dt1, qp_dt2});
        else m_ovf = 1;
      end
    end else begin
      psq.delete(); qpq.delete();
      m_tmo = 0; m_ovf = 0; m_sps = 0; m_sqp = 0; m_stmo = 0;
    end
  endtask

  // One clock: note handshakes, advance model, compare after the edge.
  task automatic step();
    bit hs1;
    hs0 = !rst && if0.cmd_vld_o && cmd_rdy;
    hs1 = !rst && if1.cmd_vld_o && cmd_rdy;
    if (hs0) log0.push_back({if0.cmd_src_o, if0.cmd_op_o});
    if (hs1) log1.push_back({if1.cmd_src_o, if1.cmd_op_o});
    if (auto_done) tx_done = (done_cnt == 1);
    @(posedge clk);
    model_update();
    if (hs0) done_cnt = 5;
    else if (done_cnt > 0) done_cnt--;
    #1;
    chk("model",
        {if0.cmd_vld_o, if0.cmd_op_o, if0.cmd_dt1_o, if0.cmd_dt2_o, if0.cmd_src_o,
         if0.busy_o, if0.ps_rdy_o, if0.qp_rdy_o, if0.tmo_err_o, if0.ovf_err_o},
        {m_vld, m_cmd.op, m_cmd.d1, m_cmd.d2, m_src,
         (m_phase != 0 || psq.size() != 0 || qpq.size() != 0),
         (psq.size() < DEPTH), (qpq.size() < DEPTH), m_tmo, m_ovf});
`ifdef XCOM_ARB_STATS_EN
    chk("model_stats", {if0.stat_ps_o, if0.stat_qp_o, if0.stat_tmo_o},
        {m_sps[15:0], m_sqp[15:0], m_stmo[7:0]});
`endif
  endtask

  task automatic do_reset();
    rst = 1; flush = 0; ps_req = 0; qp_req = 0; tx_done = 0;
    step();
    rst = 0;
    log0.delete(); log1.delete();
    done_cnt = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    vec_t tbl[$];
    int cnt;
    logic [5:0] act;

    rst = 1; flush = 0; ps_req = 0; qp_req = 0; cmd_rdy = 0; tx_done = 0;
    ps_op = 0; qp_op = 0; ps_dt1 = 0; ps_dt2 = 0; qp_dt1 = 0; qp_dt2 = 0;
    auto_done = 0; done_cnt = 0; hs0 = 0;

    // rst fl ps qp pop qop rdy done | vld op src busy prdy qrdy tmo ovf
    tbl.push_back('{1,0,0,0,0,0,0,0, 0,0,0,0,1,1,0,0});
    tbl.push_back('{0,0,1,0,2,0,1,0, 0,0,0,1,1,1,0,0});
    tbl.push_back('{0,0,0,0,0,0,1,0, 1,2,0,1,1,1,0,0});
    tbl.push_back('{0,0,0,0,0,0,1,0, 0,2,0,1,1,1,0,0});
    for (int i = 0; i < 9; i++) tbl.push_back('{0,0,0,0,0,0,1,0, 0,2,0,1,1,1,0,0});
    tbl.push_back('{0,0,0,0,0,0,0,1, 0,2,0,0,1,1,0,0});
    tbl.push_back('{0,0,1,1,5,9,1,0, 0,2,0,1,1,1,0,0});
    tbl.push_back('{0,0,0,0,0,0,1,0, 1,9,1,1,1,1,0,0});
    tbl.push_back('{0,0,0,0,0,0,1,0, 0,9,1,1,1,1,0,0});
    tbl.push_back('{0,0,0,0,0,0,0,1, 0,9,1,1,1,1,0,0});
    tbl.push_back('{0,0,0,0,0,0,0,0, 1,5,0,1,1,1,0,0});
    tbl.push_back('{0,0,0,0,0,0,1,0, 0,5,0,1,1,1,0,0});
    tbl.push_back('{0,0,0,0,0,0,0,1, 0,5,0,0,1,1,0,0});
    tbl.push_back('{0,1,1,0,3,0,0,0, 0,5,0,0,1,1,0,0});
    tbl.push_back('{0,0,0,0,0,0,0,1, 0,5,0,0,1,1,0,0});

    ps_dt1 = 32'd2; ps_dt2 = 32'd1; qp_dt1 = 32'h1234; qp_dt2 = 32'h5678;
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; flush = tbl[i].flush; ps_req = tbl[i].ps; qp_req = tbl[i].qp;
      ps_op = tbl[i].pop; qp_op = tbl[i].qop; cmd_rdy = tbl[i].rdy; tx_done = tbl[i].done;
      step();
      chk($sformatf("tbl_row%0d", i),
          {if0.cmd_vld_o, if0.cmd_op_o, if0.cmd_src_o, if0.busy_o,
           if0.ps_rdy_o, if0.qp_rdy_o, if0.tmo_err_o, if0.ovf_err_o},
          {tbl[i].vld, tbl[i].op, tbl[i].src, tbl[i].busy,
           tbl[i].prdy, tbl[i].qrdy, tbl[i].tmo, tbl[i].ovf});
    end

    // Issue order with both FIFOs preloaded
    do_reset();
    cmd_rdy = 1; auto_done = 1;
    for (int k = 0; k < 3; k++) begin
      ps_req = 1; ps_op = 5'(1 + k); qp_req = 1; qp_op = 5'(17 + k);
      step();
    end
    ps_req = 0; qp_req = 0;
    run(60);
    chk("order_rr_cnt", log0.size(), 6);
    chk("order_prio_cnt", log1.size(), 6);
    for (int k = 0; k < 6; k++) begin
      act = (k < log0.size()) ? log0[k] : 6'h3f;
      chk($sformatf("order_rr_%0d", k), act,
          (k % 2 == 0) ? {1'b0, 5'(1 + k / 2)} : {1'b1, 5'(17 + k / 2)});
      act = (k < log1.size()) ? log1[k] : 6'h3f;
      chk($sformatf("order_prio_%0d", k), act,
          (k < 3) ? {1'b1, 5'(17 + k)} : {1'b0, 5'(k - 2)});
    end

    // FIFO full: one command held in ISSUE plus DEPTH queued
    do_reset();
    cmd_rdy = 0; auto_done = 0; tx_done = 0;
    for (int k = 1; k <= 6; k++) begin
      qp_req = 1; qp_op = 5'(20 + k);
      step();
      if (k == 5) begin
        chk("qp_rdy_full", if0.qp_rdy_o, 0);
        chk("ovf_not_yet", if0.ovf_err_o, 0);
      end
      if (k == 6) chk("ovf_set", if0.ovf_err_o, 1);
    end
    qp_req = 0;
    cmd_rdy = 1; auto_done = 1;
    run(60);
    chk("full_issue_cnt", log0.size(), 5);
    for (int k = 0; k < 5; k++) begin
      act = (k < log0.size()) ? log0[k] : 6'h3f;
      chk($sformatf("full_order_%0d", k), act, {1'b1, 5'(21 + k)});
    end

    // Timeout, then next queued command issues, then flush clears the flag
    do_reset();
    auto_done = 0; tx_done = 0; cmd_rdy = 1;
    ps_req = 1; ps_op = 5'd7; step();
    ps_op = 5'd8; step();
    ps_req = 0;
    cnt = 0;
    do begin step(); cnt++; end while (!hs0 && cnt < 20);
    chk("tmo_hs_seen", hs0, 1);
    cnt = 0;
    do begin step(); cnt++; end while (!if0.tmo_err_o && cnt < 40);
    chk("tmo_latency", cnt, TMO);
    step();
    chk("tmo_next_issue", {if0.cmd_vld_o, if0.cmd_op_o}, {1'b1, 5'd8});
    flush = 1; step(); flush = 0;
    chk("tmo_flush_clr", if0.tmo_err_o, 0);

    // Reset while waiting with two commands still queued
    do_reset();
    auto_done = 0; cmd_rdy = 1;
    for (int k = 0; k < 3; k++) begin
      ps_req = 1; ps_op = 5'(11 + k); step();
    end
    ps_req = 0;
    step();
    rst = 1; step(); rst = 0;
    chk("rst_outputs",
        {if0.cmd_vld_o, if0.cmd_op_o, if0.cmd_dt1_o, if0.cmd_dt2_o, if0.cmd_src_o,
         if0.busy_o, if0.ps_rdy_o, if0.qp_rdy_o, if0.tmo_err_o, if0.ovf_err_o},
        {1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (if0.cmd_vld_o) cnt++;
    end
    chk("rst_no_vld", cnt, 0);

`ifdef XCOM_ARB_STATS_EN
    do_reset();
    cmd_rdy = 1; auto_done = 1;
    for (int k = 0; k < 3; k++) begin
      ps_req = 1; ps_op = 5'(k + 1); qp_req = (k < 2); qp_op = 5'(k + 9);
      step();
    end
    ps_req = 0; qp_req = 0;
    run(60);
    chk("stat_ps", if0.stat_ps_o, 3);
    chk("stat_qp", if0.stat_qp_o, 2);
    chk("stat_tmo", if0.stat_tmo_o, 0);
`endif

    // Random traffic against the model
    do_reset();
    auto_done = 0;
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 499) == 0);
      flush   = ($urandom_range(0, 99) == 0);
      ps_req  = ($urandom_range(0, 2) == 0);
      qp_req  = ($urandom_range(0, 2) == 0);
      ps_op   = 5'($urandom); qp_op = 5'($urandom);
      ps_dt1  = $urandom; ps_dt2 = $urandom;
      qp_dt1  = $urandom; qp_dt2 = $urandom;
      cmd_rdy = ($urandom_range(0, 1) == 0);
      tx_done = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/xcom_cmd_arbiter.md
Name: xcom_cmd_arbiter

Overview:
- Shares the single XCOM transmit command port between two requesters: the PS/AXI register path (python commands) and the tProcessor qp path.
- Each source gets a small command FIFO. A state machine picks one command, issues it to the XCOM TX core, then waits for the TX done pulse or a timeout before picking the next.
- Sits in the c_clk domain, between the qp_*/AXI command decode and the XCOM TX serializer.

Parameters:
- FIFO_AW, 2, log2 of per-source FIFO depth (depth = 2**FIFO_AW, range 1..5).
- PRIO, 0, 0 = round-robin between sources; 1 = tProc fixed priority over PS.
- TMO_CYC, 4096, c_clk cycles in WAIT before the command is declared timed out (min 2, max 2**20).

Ports:
- c_clk  in  1  command clock
- c_rst  in  1  synchronous active-high reset
- flush_i  in  1  one-cycle pulse; empties both FIFOs
- ps_req_i  in  1  PS command write strobe
- ps_op_i  in  5  PS opcode
- ps_dt1_i  in  32  PS data1 (address/flag)
- ps_dt2_i  in  32  PS data2
- ps_rdy_o  out  1  PS FIFO not full
- qp_req_i  in  1  tProc command strobe
- qp_op_i  in  5  tProc opcode
- qp_dt1_i  in  32  tProc data1
- qp_dt2_i  in  32  tProc data2
- qp_rdy_o  out  1  tProc FIFO not full
- cmd_vld_o  out  1  command valid to TX core
- cmd_rdy_i  in  1  TX core accepts command
- cmd_op_o  out  5  issued opcode
- cmd_dt1_o  out  32  issued data1
- cmd_dt2_o  out  32  issued data2
- cmd_src_o  out  1  0 = PS, 1 = tProc
- tx_done_i  in  1  one-cycle pulse; TX frame complete
- busy_o  out  1  state != IDLE, or any FIFO non-empty
- tmo_err_o  out  1  sticky timeout flag; cleared by c_rst or flush_i
- ovf_err_o  out  1  sticky; a req arrived while the matching FIFO was full

Behaviour:
- Reset (c_rst high at a c_clk edge):
  - FIFOs empty; state IDLE; round-robin pointer selects PS first.
  - Outputs: cmd_vld_o 0; cmd_op_o, cmd_dt1_o, cmd_dt2_o, cmd_src_o all 0; tmo_err_o 0; ovf_err_o 0; busy_o 0; ps_rdy_o 1; qp_rdy_o 1.
  - Reset mid-operation drops any in-flight command and all queued commands.
- Enqueue:
  - A req_i that is high while its rdy_o is high writes {op, dt1, dt2} that cycle.
  - rdy_o = !full, driven combinationally from the FIFO count.
  - A req_i while full is dropped and sets ovf_err_o.
  - PS and tProc may enqueue in the same cycle; each writes its own FIFO independently.
  - Enqueue and dequeue on the same FIFO in the same cycle: the count is unchanged and the write succeeds even when the FIFO is full.
- Dequeue and issue state machine:
  - IDLE: if either FIFO is non-empty, select a source:
    - PRIO=1: tProc whenever non-empty.
    - PRIO=0: alternate when both are non-empty; the pointer flips after each grant to point at the other source.
    - Pop the selected head into the output registers, set cmd_vld_o=1 on the next edge, go to ISSUE. IDLE-to-ISSUE latency is 1 cycle.
  - ISSUE: hold cmd_vld_o and the data stable until cmd_rdy_i=1. On that handshake edge, cmd_vld_o drops to 0, the timer clears, and the state goes to WAIT.
  - WAIT:
    - tx_done_i returns to IDLE.
    - If the timer reaches TMO_CYC-1 first: set tmo_err_o, return to IDLE.
    - tx_done_i in the same cycle as the timeout counts as done; tmo_err_o is not set.
    - tx_done_i outside WAIT is ignored.
  - Minimum spacing between two handshakes: 3 cycles (handshake, done, next IDLE pop).
- flush_i:
  - Empties both FIFOs and clears tmo_err_o and ovf_err_o.
  - Does not abort an ISSUE or WAIT already in progress.
  - A req_i in the same cycle as flush_i is dropped, and ovf_err_o is not set.
- Count wrap: FIFO pointers are FIFO_AW+1 bits and wrap modulo 2**(FIFO_AW+1). Full = MSBs differ and the lower bits are equal.
- Opcode and data pass through unmodified; no width conversion.

Optional Feature:
- Macro XCOM_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_ps_o[15:0], stat_qp_o[15:0] (commands granted per source) and stat_tmo_o[7:0] (timeouts).
  - All three saturate at all-ones and are cleared by c_rst or flush_i.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, then ps_req with op=2, dt1=2, dt2=1 while cmd_rdy_i=1:
  - cmd_vld_o rises 2 cycles after the req, carrying op=2, src=0.
  - A tx_done_i after 10 cycles returns to IDLE; busy_o ends 0.
- PRIO=0, both FIFOs preloaded with 3 commands, tx_done_i 5 cycles after each handshake:
  - Issue order is PS, QP, PS, QP, PS, QP.
  - With PRIO=1 the order is QP, QP, QP, PS, PS, PS.
- FIFO_AW=2 with cmd_rdy_i=0, 6 qp_req pulses:
  - qp_rdy_o is 0 after the 5th accepted command (4 in the FIFO plus 1 held in ISSUE); the 6th sets ovf_err_o.
  - After releasing cmd_rdy_i, exactly 5 commands are issued in order.
- TMO_CYC=16, one command, no tx_done_i:
  - tmo_err_o sets 16 cycles after the handshake; the next queued command then issues.
  - flush_i clears tmo_err_o.
- c_rst asserted during WAIT with 2 commands queued:
  - All outputs return to reset values the next cycle; no further cmd_vld_o.
- With XCOM_ARB_STATS_EN defined, 3 PS and 2 QP commands completed:
  - stat_ps_o=3, stat_qp_o=2, stat_tmo_o=0.
